// File: rtl/exe_wb_arbiter_pkg.sv
// Shared types and default sizing for the execute-stage writeback arbiter.
// The rr_wrap helper steps a round-robin index modulo the FU count.
package exe_wb_arbiter_pkg;

  localparam int NUM_EXE_FU   = 4;
  localparam int NUM_WB_PORTS = 2;
  localparam int EXE_XLEN     = 32;
  localparam int EXE_PRF_W    = 6;
  localparam int EXE_ROB_W    = 5;

  typedef struct packed {
    logic                 wb_en;
    logic [EXE_PRF_W-1:0] wb_addr;
    logic [EXE_XLEN-1:0]  wb_data;
    logic [EXE_ROB_W-1:0] rob_idx;
    logic [31:0]          pc;
  } exe_wb_req_t;

  // Wraps an index in [0, 2n) back into [0, n).
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/exe_wb_arbiter_fifo.sv
// Per-FU in-order result FIFO with combinational head.
// Supports simultaneous enqueue/dequeue; flush and reset empty it.
module exe_wb_fifo #(
  parameter int  BUF_DEPTH = 2,
  parameter type T         = logic,
  localparam int PTR_W     = $clog2(BUF_DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq,
  input  T                 enq_data,
  input  logic             deq,
  output T                 head,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  T                 r_mem [BUF_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  // Storage is left unreset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (enq) r_mem[r_wr_ptr] <= enq_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign empty = (r_count == '0);
  assign full  = (r_count == CNT_W'(BUF_DEPTH));
  assign count = r_count;

endmodule

// File: rtl/exe_wb_arbiter.sv
// Buffers FU results per source and grants up to NUM_WB_PORTS of them per
// cycle, round-robin, onto PRF writeback / ROB completion / wakeup ports.
module exe_wb_arbiter #(
  parameter int NUM_FU       = exe_wb_arbiter_pkg::NUM_EXE_FU,
  parameter int NUM_WB_PORTS = exe_wb_arbiter_pkg::NUM_WB_PORTS,
  parameter int BUF_DEPTH    = 2,
  parameter int XLEN         = 32,
  parameter int PRF_ADDR_W   = 6,
  parameter int ROB_IDX_W    = 5
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    flush,
  input  logic [NUM_FU-1:0]                       fu_valid,
  output logic [NUM_FU-1:0]                       fu_ready,
  input  logic [NUM_FU-1:0]                       fu_wb_en,
  input  logic [NUM_FU-1:0][PRF_ADDR_W-1:0]       fu_wb_addr,
  input  logic [NUM_FU-1:0][XLEN-1:0]             fu_wb_data,
  input  logic [NUM_FU-1:0][ROB_IDX_W-1:0]        fu_rob_idx,
  input  logic [NUM_FU-1:0][31:0]                 fu_pc,
  output logic [NUM_WB_PORTS-1:0]                 wb_valid,
  output logic [NUM_WB_PORTS-1:0]                 wb_en,
  output logic [NUM_WB_PORTS-1:0][PRF_ADDR_W-1:0] wb_addr,
  output logic [NUM_WB_PORTS-1:0][XLEN-1:0]       wb_data,
  output logic [NUM_WB_PORTS-1:0][ROB_IDX_W-1:0]  wb_rob_idx,
  output logic [NUM_WB_PORTS-1:0][31:0]           wb_pc,
  output logic [NUM_WB_PORTS-1:0]                 bcast_valid,
  output logic [NUM_WB_PORTS-1:0][PRF_ADDR_W-1:0] bcast_prf
);

  import exe_wb_arbiter_pkg::*;

  localparam int RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  typedef struct packed {
    logic                  wb_en;
    logic [PRF_ADDR_W-1:0] wb_addr;
    logic [XLEN-1:0]       wb_data;
    logic [ROB_IDX_W-1:0]  rob_idx;
    logic [31:0]           pc;
  } req_t;

  req_t                w_head  [NUM_FU];
  logic [CNT_W-1:0]    w_count [NUM_FU];
  logic [NUM_FU-1:0]   w_empty;
  logic [NUM_FU-1:0]   w_full;
  logic [NUM_FU-1:0]   w_enq;
  logic [NUM_FU-1:0]   w_deq;
  logic [NUM_FU-1:0]   w_grant;

  logic [NUM_WB_PORTS-1:0] w_port_valid;
  logic [RR_W-1:0]         w_port_sel [NUM_WB_PORTS];
  logic                    w_any_grant;
  logic [RR_W-1:0]         w_rr_next;
  logic [RR_W-1:0]         r_rr;

  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
    req_t w_enq_data;

    assign w_enq_data = '{wb_en:   fu_wb_en[gi],
                          wb_addr: fu_wb_addr[gi],
                          wb_data: fu_wb_data[gi],
                          rob_idx: fu_rob_idx[gi],
                          pc:      fu_pc[gi]};

    // Ready comes from the registered count only, so a full FIFO stays
    // not-ready even while its head is being granted.
    assign fu_ready[gi] = (w_count[gi] != CNT_W'(BUF_DEPTH));
    assign w_enq[gi]    = fu_valid[gi] & ~w_full[gi] & ~flush;
    assign w_deq[gi]    = w_grant[gi] & ~flush;

    exe_wb_fifo #(
      .BUF_DEPTH (BUF_DEPTH),
      .T         (req_t)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .enq      (w_enq[gi]),
      .enq_data (w_enq_data),
      .deq      (w_deq[gi]),
      .head     (w_head[gi]),
      .empty    (w_empty[gi]),
      .full     (w_full[gi]),
      .count    (w_count[gi])
    );
  end

  always_comb begin
    int              n_granted;
    logic [RR_W-1:0] idx;
    w_grant      = '0;
    w_port_valid = '0;
    w_any_grant  = 1'b0;
    w_rr_next    = r_rr;
    n_granted    = 0;
    idx          = '0;
    for (int k = 0; k < NUM_WB_PORTS; k++) w_port_sel[k] = '0;
    for (int o = 0; o < NUM_FU; o++) begin
      idx = RR_W'(rr_wrap(int'(r_rr) + o, NUM_FU));
      if (!w_empty[idx] && n_granted < NUM_WB_PORTS) begin
        w_grant[idx] = 1'b1;
        for (int k = 0; k < NUM_WB_PORTS; k++) begin
          if (k == n_granted) begin
            w_port_valid[k] = 1'b1;
            w_port_sel[k]   = idx;
          end
        end
        w_any_grant = 1'b1;
        w_rr_next   = RR_W'(rr_wrap(int'(idx) + 1, NUM_FU));
        n_granted   = n_granted + 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rr <= '0;
    end else if (w_any_grant) begin
      r_rr <= w_rr_next;
    end
  end

  for (genvar gi = 0; gi < NUM_WB_PORTS; gi++) begin : g_port
    req_t w_sel;

    assign w_sel           = w_port_valid[gi] ? w_head[w_port_sel[gi]] : '0;
    assign wb_valid[gi]    = w_port_valid[gi];
    assign wb_en[gi]       = w_sel.wb_en;
    assign wb_addr[gi]     = w_sel.wb_addr;
    assign wb_data[gi]     = w_sel.wb_data;
    assign wb_rob_idx[gi]  = w_sel.rob_idx;
    assign wb_pc[gi]       = w_sel.pc;
    assign bcast_valid[gi] = w_port_valid[gi] & w_sel.wb_en;
    assign bcast_prf[gi]   = w_sel.wb_addr;
  end

endmodule

// File: tb/tb_exe_wb_arbiter.sv
// Directed bench for exe_wb_arbiter: reset/idle, single result, contention,
// wb_en=0, backpressure with per-FU ordering scoreboard, flush and reset.
module tb_exe_wb_arbiter;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic [3:0]       fu_valid;
  logic [3:0]       fu_ready;
  logic [3:0]       fu_wb_en;
  logic [3:0][5:0]  fu_wb_addr;
  logic [3:0][31:0] fu_wb_data;
  logic [3:0][4:0]  fu_rob_idx;
  logic [3:0][31:0] fu_pc;
  logic [1:0]       wb_valid;
  logic [1:0]       wb_en;
  logic [1:0][5:0]  wb_addr;
  logic [1:0][31:0] wb_data;
  logic [1:0][4:0]  wb_rob_idx;
  logic [1:0][31:0] wb_pc;
  logic [1:0]       bcast_valid;
  logic [1:0][5:0]  bcast_prf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  exe_wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .fu_valid    (fu_valid),
    .fu_ready    (fu_ready),
    .fu_wb_en    (fu_wb_en),
    .fu_wb_addr  (fu_wb_addr),
    .fu_wb_data  (fu_wb_data),
    .fu_rob_idx  (fu_rob_idx),
    .fu_pc       (fu_pc),
    .wb_valid    (wb_valid),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .wb_rob_idx  (wb_rob_idx),
    .wb_pc       (wb_pc),
    .bcast_valid (bcast_valid),
    .bcast_prf   (bcast_prf)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    fu_valid   = '0;
    fu_wb_en   = '0;
    fu_wb_addr = '0;
    fu_wb_data = '0;
    fu_rob_idx = '0;
    fu_pc      = '0;
  endtask

  // PC encodes the source FU in bits [9:8] so the bench can attribute grants.
  task automatic put(input int fu, input logic en, input logic [5:0] addr,
                     input logic [31:0] data, input logic [4:0] rob);
    fu_valid[fu]   = 1'b1;
    fu_wb_en[fu]   = en;
    fu_wb_addr[fu] = addr;
    fu_wb_data[fu] = data;
    fu_rob_idx[fu] = rob;
    fu_pc[fu]      = 32'h1000 + (fu << 8) + 32'(rob);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++)
      if (!rst && wb_valid[k])
        $display("WB t=%0t port%0d pc=%08h rob=%0d addr=%0h data=%08h en=%0b",
                 $time, k, wb_pc[k], wb_rob_idx[k], wb_addr[k], wb_data[k], wb_en[k]);
  end

  int exp_q [4][$];
  int cnt [4];
  int seq [4];
  int pop [4];
  int acc;
  int f;
  logic saw_drop;

  initial begin
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset then idle
    for (int c = 0; c < 10; c++) begin
      chk("idle_ready", fu_ready, 4'hF);
      chk("idle_wb_valid", wb_valid, 2'b00);
      @(negedge clk);
    end

    // Single result on FU2
    put(2, 1'b1, 6'h15, 32'hDEADBEEF, 5'd7);
    @(negedge clk);
    clear_inputs();
    chk("single_valid", wb_valid, 2'b01);
    chk("single_en", wb_en[0], 1'b1);
    chk("single_addr", wb_addr[0], 6'h15);
    chk("single_data", wb_data[0], 32'hDEADBEEF);
    chk("single_rob", wb_rob_idx[0], 5'd7);
    chk("single_pc", wb_pc[0], 32'h1207);
    chk("single_bvalid", bcast_valid, 2'b01);
    chk("single_bprf", bcast_prf[0], 6'h15);
    @(negedge clk);
    chk("single_drained", wb_valid, 2'b00);

    // Contention: all four FUs at once with rr = 0
    do_reset();
    for (int i = 0; i < 4; i++) put(i, 1'b1, 6'(6'h10 + i), 32'hA0000000 + i, 5'(i + 1));
    @(negedge clk);
    clear_inputs();
    chk("cont1_valid", wb_valid, 2'b11);
    chk("cont1_rob0", wb_rob_idx[0], 5'd1);
    chk("cont1_rob1", wb_rob_idx[1], 5'd2);
    chk("cont1_data1", wb_data[1], 32'hA0000001);
    chk("cont1_bprf1", bcast_prf[1], 6'h11);
    @(negedge clk);
    chk("cont2_valid", wb_valid, 2'b11);
    chk("cont2_rob0", wb_rob_idx[0], 5'd3);
    chk("cont2_rob1", wb_rob_idx[1], 5'd4);
    @(negedge clk);
    chk("cont3_valid", wb_valid, 2'b00);
    // rr must be back at 0: FU0/FU1 win over FU2
    for (int i = 0; i < 3; i++) put(i, 1'b1, 6'h20, 32'h0, 5'(i + 8));
    @(negedge clk);
    clear_inputs();
    chk("rr0_rob0", wb_rob_idx[0], 5'd8);
    chk("rr0_rob1", wb_rob_idx[1], 5'd9);
    @(negedge clk);
    chk("rr2_valid", wb_valid, 2'b01);
    chk("rr2_rob0", wb_rob_idx[0], 5'd10);
    @(negedge clk);

    // wb_en = 0 (branch result) on FU1
    put(1, 1'b0, 6'h09, 32'h1234, 5'd12);
    @(negedge clk);
    clear_inputs();
    chk("br_valid", wb_valid, 2'b01);
    chk("br_en", wb_en[0], 1'b0);
    chk("br_bvalid", bcast_valid, 2'b00);
    chk("br_rob", wb_rob_idx[0], 5'd12);
    @(negedge clk);

    // Backpressure: all FUs saturate, scoreboard per-FU ROB order
    do_reset();
    saw_drop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      seq[i] = 0;
    end
    for (int cyc = 0; cyc < 20; cyc++) begin
      for (int i = 0; i < 4; i++) pop[i] = 0;
      for (int k = 0; k < 2; k++) begin
        if (wb_valid[k]) begin
          f = int'(wb_pc[k][9:8]);
          chk("bp_has_entry", exp_q[f].size() != 0, 1'b1);
          if (exp_q[f].size() != 0) chk("bp_rob_order", wb_rob_idx[k], 5'(exp_q[f].pop_front()));
          pop[f]++;
        end
      end
      for (int i = 0; i < 4; i++) chk("bp_ready", fu_ready[i], cnt[i] != 2);
      if (!fu_ready[0]) saw_drop = 1'b1;
      clear_inputs();
      for (int i = 0; i < 4; i++) begin
        acc = 0;
        if (cyc < 10) begin
          put(i, 1'b1, 6'(i), 32'(seq[i]), 5'(seq[i]));
          if (cnt[i] != 2) begin
            exp_q[i].push_back(seq[i]);
            seq[i]++;
            acc = 1;
          end
        end
        cnt[i] = cnt[i] + acc - pop[i];
      end
      @(negedge clk);
    end
    chk("bp_fu0_ready_drop", saw_drop, 1'b1);
    for (int i = 0; i < 4; i++) chk("bp_all_drained", exp_q[i].size(), 0);

    // Flush with three buffered results plus a new FU3 result
    for (int i = 0; i < 3; i++) put(i, 1'b1, 6'h30, 32'h0, 5'(20 + i));
    @(negedge clk);
    clear_inputs();
    flush = 1'b1;
    put(3, 1'b1, 6'h31, 32'h0, 5'd30);
    chk("flush_cycle_valid", wb_valid, 2'b11);
    @(negedge clk);
    flush = 1'b0;
    clear_inputs();
    chk("flush_after_valid", wb_valid, 2'b00);
    chk("flush_after_ready", fu_ready, 4'hF);
    put(3, 1'b1, 6'h2A, 32'hCAFEF00D, 5'h1A);
    @(negedge clk);
    clear_inputs();
    chk("post_flush_valid", wb_valid, 2'b01);
    chk("post_flush_rob", wb_rob_idx[0], 5'h1A);
    chk("post_flush_data", wb_data[0], 32'hCAFEF00D);
    @(negedge clk);
    chk("post_flush_drained", wb_valid, 2'b00);

    // Reset mid-operation discards buffered results
    put(0, 1'b1, 6'h01, 32'h1, 5'd1);
    put(1, 1'b1, 6'h02, 32'h2, 5'd2);
    put(2, 1'b1, 6'h03, 32'h3, 5'd3);
    @(negedge clk);
    do_reset();
    chk("midrst_valid", wb_valid, 2'b00);
    chk("midrst_ready", fu_ready, 4'hF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exe_wb_arbiter.md
Name: exe_wb_arbiter

Overview:
- Parametrised writeback/broadcast arbiter for the execute stage.
- Accepts completed results from NUM_FU functional units and buffers them per FU.
- Each cycle, grants up to NUM_WB_PORTS results by rotating round-robin.
- Drives granted results to PRF write-back, ROB completion and IQ/rename wakeup broadcast, so the FU count is no longer tied to the register-file write-port count.

Parameters:
- NUM_FU, 4, number of FU result sources.
- NUM_WB_PORTS, 2, writeback/broadcast ports per cycle (1..NUM_FU).
- BUF_DEPTH, 2, per-FU result FIFO entries (power of two, >=2).
- XLEN, 32, data width.
- PRF_ADDR_W, 6, physical register index width.
- ROB_IDX_W, 5, ROB index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush (mispredict/exception)
- fu_valid  in  [NUM_FU]  FU result valid
- fu_ready  out  [NUM_FU]  arbiter can accept result from FU
- fu_wb_en  in  [NUM_FU]  result writes a PRF register
- fu_wb_addr  in  [NUM_FU][PRF_ADDR_W]  destination PRF index
- fu_wb_data  in  [NUM_FU][XLEN]  result data
- fu_rob_idx  in  [NUM_FU][ROB_IDX_W]  ROB entry
- fu_pc  in  [NUM_FU][32]  instruction PC (debug/trace)
- wb_valid  out  [NUM_WB_PORTS]  port carries a result (ROB completion)
- wb_en  out  [NUM_WB_PORTS]  PRF write enable
- wb_addr  out  [NUM_WB_PORTS][PRF_ADDR_W]  PRF index
- wb_data  out  [NUM_WB_PORTS][XLEN]  data
- wb_rob_idx  out  [NUM_WB_PORTS][ROB_IDX_W]  ROB entry
- wb_pc  out  [NUM_WB_PORTS][32]  PC
- bcast_valid  out  [NUM_WB_PORTS]  wakeup valid (= wb_valid & wb_en)
- bcast_prf  out  [NUM_WB_PORTS][PRF_ADDR_W]  wakeup tag (= wb_addr)

Behaviour:
- Reset (rst=1 at posedge):
  - All FIFOs empty; rr pointer = 0.
  - fu_ready = all 1 from the next cycle.
  - All wb_*/bcast_* valids = 0; data outputs are don't-care but driven to 0.
- Handshake:
  - Transfer when fu_valid[i] & fu_ready[i] at posedge.
  - fu_ready[i] = (count[i] != BUF_DEPTH), computed from registered count only; there is no combinational path from fu_valid or grants.
  - A full FIFO stays not-ready even in a cycle in which it is dequeued.
- FIFO: one per FU, in-order, enqueue and dequeue in the same cycle allowed. Count is updated +1/-1/0 accordingly; pointers wrap mod BUF_DEPTH.
- Latency: a result accepted at posedge E0 is eligible in the cycle following E0. Minimum 1 cycle from fu_valid to wb_valid.
- Arbitration (combinational over FIFO heads, each cycle):
  - Scan FUs starting at index rr, ascending mod NUM_FU.
  - The first NUM_WB_PORTS non-empty FIFOs are granted; the k-th grant drives port k.
  - Ports not granted: wb_valid = 0, bcast_valid = 0.
  - Granted heads are dequeued at the next posedge.
- rr update:
  - If any grant, rr <= (index of last granted FU + 1) mod NUM_FU; otherwise unchanged.
  - Guarantees each non-empty FU is granted within ceil(NUM_FU/NUM_WB_PORTS) cycles.
- wb_en = 0 results (branches, stores without rd):
  - Still occupy a port and signal ROB completion (wb_valid = 1).
  - bcast_valid = 0.
- Outputs are driven combinationally from FIFO heads; no extra register stage.
- Flush:
  - Flush at posedge empties all FIFOs and sets rr = 0.
  - fu_valid in the flush cycle is discarded.
  - Outputs in the flush cycle are still driven from current heads; consumers gate them with flush.
  - Outputs are invalid the cycle after.
- Simultaneous flush and rst: rst dominates (identical end state).
- Reset mid-operation discards all buffered results; no partial writeback.

Decomposition:
- Falco_pkg additions:
  - exe_wb_req_t {wb_en, wb_addr, wb_data, rob_idx, pc}.
  - Constants NUM_EXE_FU and NUM_WB_PORTS, used by top-level instantiation.
- Existing exe_fu_wb_t and exe_broadcast_t are produced by unpacking the port outputs at the exe_stage_io connection.
- Sub-module exe_wb_fifo:
  - Parametrised by BUF_DEPTH and payload type.
  - Inputs: enq/deq/flush. Outputs: head, empty, full, count.
  - Instantiated NUM_FU times via generate.
- Arbiter logic stays in the top module.

Test Plan:
- Reset, then idle: all fu_ready = 1 and all wb_valid = 0 for 10 cycles.
- Single result:
  - Stimulus: FU2 valid, wb_en = 1, addr 0x15, data 0xDEADBEEF, rob 7 at cycle c.
  - Required: port0 valid in c+1 with identical fields, bcast_prf = 0x15; port1 invalid.
- Contention:
  - Stimulus: all 4 FUs valid in the same cycle (NUM_WB_PORTS = 2, rr = 0).
  - Required: FU0/FU1 on ports 0/1 in cycle c+1, FU2/FU3 in c+2, rr = 0 after.
- Backpressure:
  - Stimulus: FU0 valid every cycle while FUs 1-3 also saturate (BUF_DEPTH = 2).
  - Required: fu_ready[0] drops once count reaches 2. No result is lost or duplicated; the ROB-index sequence per FU is preserved in order.
- wb_en = 0:
  - Stimulus: FU1 branch result, wb_en = 0.
  - Required: wb_valid = 1, wb_en = 0, bcast_valid = 0 on the granted port.
- Flush with 3 buffered results plus a new fu_valid in the flush cycle:
  - Required: next cycle all wb_valid = 0 and all fu_ready = 1.
  - Required: a subsequent result on FU3 appears after 1 cycle on port0.
